// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches the word at pc_in over an imem req/ack handshake,
// presents it to decode over valid/ready, and computes pc_next. Optional trap: FETCH_MISALIGN_TRAP_EN.
module instr_fetch_unit #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_STEP = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [XLEN-1:0]  pc_in,
    output logic [XLEN-1:0]  pc_next,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ack,
    input  logic [XLEN-1:0]  imem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [XLEN-1:0]  instr_out,
    output logic [XLEN-1:0]  instr_pc,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_target,
    output logic [CNT_W-1:0] fetch_count,
    output logic             trap
);

    localparam logic [1:0] S_FETCH    = 2'd0;
    localparam logic [1:0] S_WAIT_ACK = 2'd1;
    localparam logic [1:0] S_ISSUE    = 2'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [1:0] S_TRAP     = 2'd3;
`endif

    logic [1:0]       state_q, state_d;
    logic [XLEN-1:0]  addr_q, addr_d;
    logic [XLEN-1:0]  instr_q, instr_d;
    logic [XLEN-1:0]  ipc_q, ipc_d;
    logic [XLEN-1:0]  tgt_q, tgt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             drop_q, drop_d;
    logic             req_c;
    logic [XLEN-1:0]  raw_addr;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        drop_d  = drop_q;
        pc_next = pc_in;
        req_c   = 1'b0;
        case (state_q)
            S_FETCH: begin
`ifdef FETCH_MISALIGN_TRAP_EN
                if (pc_in[1:0] != 2'b00) begin
                    state_d = S_TRAP;
                    ipc_d   = pc_in;
                end else
`endif
                begin
                    req_c  = 1'b1;
                    addr_d = pc_in;
                    if (redirect_valid && imem_ack) begin
                        pc_next = redirect_target;
                        pend_d  = 1'b0;
                        drop_d  = 1'b0;
                    end else if (redirect_valid) begin
                        tgt_d   = redirect_target;
                        pend_d  = 1'b1;
                        drop_d  = 1'b1;
                        state_d = S_WAIT_ACK;
                    end else if (imem_ack) begin
                        instr_d = imem_rdata;
                        ipc_d   = pc_in;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_WAIT_ACK;
                    end
                end
            end
            S_WAIT_ACK: begin
                req_c = 1'b1;
                // A redirect seen with or before the ack kills the response; newest target wins.
                if (imem_ack && (redirect_valid || drop_q)) begin
                    pc_next = redirect_valid ? redirect_target : tgt_q;
                    pend_d  = 1'b0;
                    drop_d  = 1'b0;
                    state_d = S_FETCH;
                end else if (redirect_valid) begin
                    tgt_d  = redirect_target;
                    pend_d = 1'b1;
                    drop_d = 1'b1;
                end else if (imem_ack) begin
                    instr_d = imem_rdata;
                    ipc_d   = addr_q;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (instr_ready) begin
                    if (redirect_valid) begin
                        pc_next = redirect_target;
                    end else if (pend_q) begin
                        pc_next = tgt_q;
                    end else begin
                        pc_next = ipc_q + XLEN'(PC_STEP);
                    end
                    cnt_d   = cnt_q + CNT_W'(1);
                    pend_d  = 1'b0;
                    state_d = S_FETCH;
                end else if (redirect_valid) begin
                    tgt_d  = redirect_target;
                    pend_d = 1'b1;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_TRAP: begin
                state_d = S_TRAP;
            end
`endif
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
            addr_q  <= '0;
            instr_q <= '0;
            ipc_q   <= '0;
            tgt_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            drop_q  <= drop_d;
        end
    end

    // Reset state is FETCH, so the request is gated by reset to drop it asynchronously.
    assign imem_req    = req_c & reset;
    assign raw_addr    = (state_q == S_FETCH) ? pc_in : addr_q;
    assign instr_valid = (state_q == S_ISSUE);
    assign instr_out   = instr_q;
    assign instr_pc    = ipc_q;
    assign fetch_count = cnt_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign imem_addr   = raw_addr;
    assign trap        = (state_q == S_TRAP);
`else
    assign imem_addr   = raw_addr & ~XLEN'(3);
    assign trap        = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: PC register and wait-state memory in the bench,
// directed scenarios plus a randomized run against a transaction-level stream model.
module tb_instr_fetch_unit;

    localparam int CW = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   pc_in, pc_next, imem_addr, imem_rdata, instr_out, instr_pc, redirect_target;
    logic          imem_req, imem_ack, instr_valid, instr_ready, redirect_valid, trap;
    logic [CW-1:0] fetch_count;

    int            n_checks = 0;
    int            n_fails  = 0;
    logic [31:0]   pc_init  = 32'h0;
    int            mem_wait = 0;
    bit            const_mem = 1'b0;
    bit            spurious  = 1'b0;

    instr_fetch_unit #(.XLEN(32), .PC_STEP(4), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset), .pc_in(pc_in), .pc_next(pc_next),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_out(instr_out),
        .instr_pc(instr_pc), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .fetch_count(fetch_count), .trap(trap)
    );

    always #5 clock = ~clock;

    // PC register closing the fetch loop.
    always @(posedge clock or negedge reset) begin
        if (!reset) pc_in <= pc_init;
        else        pc_in <= pc_next;
    end

    function automatic logic [31:0] memfun(input logic [31:0] a);
        if (const_mem) return 32'h0000_0013;
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // Memory: mem_wait wait states per request (negative = random 0..3).
    initial begin
        int cnt;
        bit busy;
        cnt = 0; busy = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0;
        forever begin
            @(negedge clock);
            #1;
            if (!reset) begin
                imem_ack = 1'b0; busy = 1'b0;
            end else if (imem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    cnt = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
                end
                if (cnt == 0) begin
                    imem_ack = 1'b1; imem_rdata = memfun(imem_addr); busy = 1'b0;
                end else begin
                    imem_ack = 1'b0; imem_rdata = $urandom; cnt--;
                end
            end else begin
                imem_ack = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
                imem_rdata = $urandom;
                busy = 1'b0;
            end
        end
    end

    task automatic do_reset(input logic [31:0] p);
        @(negedge clock);
        pc_init = p;
        reset = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        #2;
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fails++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
        n_checks++; if (instr_out !== 32'h0) begin n_fails++; $display("FAIL reset_instr got=%h exp=0", instr_out); end
        n_checks++; if (instr_pc !== 32'h0) begin n_fails++; $display("FAIL reset_ipc got=%h exp=0", instr_pc); end
        n_checks++; if (fetch_count !== '0) begin n_fails++; $display("FAIL reset_count got=%h exp=0", fetch_count); end
        n_checks++; if (trap !== 1'b0) begin n_fails++; $display("FAIL reset_trap got=%b exp=0", trap); end
        n_checks++; if (pc_next !== pc_init) begin n_fails++; $display("FAIL reset_pcnext got=%h exp=%h", pc_next, pc_init); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] e;
        mem_wait = 0; const_mem = 1'b1; spurious = 1'b0;
        do_reset(32'h0);
        instr_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #2;
            e = 32'(4 * (k / 2));
            if (k % 2 == 0) begin
                n_checks++;
                if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, e}) begin
                    n_fails++; $display("FAIL zw_fetch k=%0d got req=%b val=%b addr=%h exp req=1 val=0 addr=%h", k, imem_req, instr_valid, imem_addr, e);
                end
            end else begin
                n_checks++;
                if ({instr_valid, instr_pc, instr_out} !== {1'b1, e, 32'h13}) begin
                    n_fails++; $display("FAIL zw_issue k=%0d got val=%b pc=%h ins=%h exp val=1 pc=%h ins=00000013", k, instr_valid, instr_pc, instr_out, e);
                end
            end
            @(negedge clock);
        end
        #2;
        n_checks++; if (fetch_count !== CW'(3)) begin n_fails++; $display("FAIL zw_count got=%0d exp=3", fetch_count); end
        const_mem = 1'b0;
    endtask

    task automatic test_wait_states();
        mem_wait = 3; spurious = 1'b0;
        do_reset(32'h100);
        instr_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #2;
            n_checks++;
            if ({imem_req, instr_valid, imem_addr} !== {1'b1, 1'b0, 32'h100}) begin
                n_fails++; $display("FAIL ws_hold k=%0d got req=%b val=%b addr=%h exp req=1 val=0 addr=00000100", k, imem_req, instr_valid, imem_addr);
            end
            @(negedge clock);
        end
        #2;
        n_checks++; if (instr_valid !== 1'b1) begin n_fails++; $display("FAIL ws_valid got=%b exp=1", instr_valid); end
        n_checks++; if (instr_pc !== 32'h100) begin n_fails++; $display("FAIL ws_ipc got=%h exp=00000100", instr_pc); end
        n_checks++; if (instr_out !== memfun(32'h100)) begin n_fails++; $display("FAIL ws_instr got=%h exp=%h", instr_out, memfun(32'h100)); end
        n_checks++; if (pc_next !== 32'h104) begin n_fails++; $display("FAIL ws_pcnext got=%h exp=00000104", pc_next); end
    endtask

    task automatic test_ready_stall();
        logic [31:0] p;
        bit found;
        p = $urandom & 32'hFFFF_FFFC;
        mem_wait = -1; spurious = 1'b1; found = 1'b0;
        do_reset(p);
        for (int i = 0; i < 20 && !found; i++) begin
            #2;
            if (instr_valid) found = 1'b1;
            else @(negedge clock);
        end
        n_checks++; if (!found) begin n_fails++; $display("FAIL stall_timeout got=no_valid exp=valid"); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({instr_valid, instr_pc, instr_out, pc_next} !== {1'b1, p, memfun(p), p}) begin
                n_fails++; $display("FAIL stall_hold i=%0d got val=%b pc=%h ins=%h nxt=%h exp pc=%h ins=%h nxt=%h", i, instr_valid, instr_pc, instr_out, pc_next, p, memfun(p), p);
            end
            @(negedge clock);
            #2;
        end
        instr_ready = 1'b1;
        #1;
        n_checks++; if (pc_next !== p + 32'd4) begin n_fails++; $display("FAIL stall_release got=%h exp=%h", pc_next, p + 32'd4); end
        @(negedge clock);
        #2;
        n_checks++; if (fetch_count !== CW'(1)) begin n_fails++; $display("FAIL stall_count got=%0d exp=1", fetch_count); end
        spurious = 1'b0;
    endtask

    task automatic test_redirect_wait();
        logic [31:0] acked[$];
        bit found;
        mem_wait = 3; spurious = 1'b0; found = 1'b0;
        do_reset(32'h40);
        instr_ready = 1'b1;
        @(negedge clock);
        redirect_valid = 1'b1; redirect_target = 32'h200;
        #2;
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h40}) begin n_fails++; $display("FAIL rw_wait got req=%b addr=%h exp req=1 addr=00000040", imem_req, imem_addr); end
        @(negedge clock);
        redirect_valid = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            #2;
            if (instr_valid) begin
                found = 1'b1;
            end else begin
                if (imem_req && imem_ack) begin
                    acked.push_back(imem_addr);
                    if (imem_addr == 32'h40) begin
                        n_checks++; if (pc_next !== 32'h200) begin n_fails++; $display("FAIL rw_drop_pcnext got=%h exp=00000200", pc_next); end
                    end
                end
                @(negedge clock);
            end
        end
        n_checks++; if (!found) begin n_fails++; $display("FAIL rw_timeout got=no_valid exp=valid"); end
        n_checks++; if (instr_pc !== 32'h200) begin n_fails++; $display("FAIL rw_first_pc got=%h exp=00000200", instr_pc); end
        n_checks++; if (instr_out !== memfun(32'h200)) begin n_fails++; $display("FAIL rw_first_ins got=%h exp=%h", instr_out, memfun(32'h200)); end
        n_checks++;
        if (acked.size() != 2 || acked[0] !== 32'h40 || acked[1] !== 32'h200) begin
            n_fails++; $display("FAIL rw_fetch_seq got size=%0d exp 00000040,00000200", acked.size());
        end
    endtask

    task automatic test_redirect_fetch();
        mem_wait = 0; spurious = 1'b0;
        do_reset(32'h80);
        instr_ready = 1'b1;
        redirect_valid = 1'b1; redirect_target = 32'h300;
        #2;
        n_checks++; if ({instr_valid, pc_next} !== {1'b0, 32'h300}) begin n_fails++; $display("FAIL rf_coincide got val=%b nxt=%h exp val=0 nxt=00000300", instr_valid, pc_next); end
        @(negedge clock);
        redirect_valid = 1'b0;
        #2;
        n_checks++; if ({instr_valid, imem_req, imem_addr} !== {1'b0, 1'b1, 32'h300}) begin n_fails++; $display("FAIL rf_refetch got val=%b req=%b addr=%h exp val=0 req=1 addr=00000300", instr_valid, imem_req, imem_addr); end
        @(negedge clock);
        #2;
        n_checks++; if ({instr_valid, instr_pc} !== {1'b1, 32'h300}) begin n_fails++; $display("FAIL rf_issue got val=%b pc=%h exp val=1 pc=00000300", instr_valid, instr_pc); end
        instr_ready = 1'b0;
        redirect_valid = 1'b1; redirect_target = 32'h400;
        #1;
        n_checks++; if (pc_next !== 32'h300) begin n_fails++; $display("FAIL rf_stall_hold got=%h exp=00000300", pc_next); end
        @(negedge clock);
        redirect_target = 32'h500;
        @(negedge clock);
        redirect_valid = 1'b0;
        #2;
        n_checks++; if ({instr_valid, instr_pc, pc_next} !== {1'b1, 32'h300, 32'h300}) begin n_fails++; $display("FAIL rf_pending got val=%b pc=%h nxt=%h exp val=1 pc=00000300 nxt=00000300", instr_valid, instr_pc, pc_next); end
        @(negedge clock);
        instr_ready = 1'b1;
        #2;
        n_checks++; if (pc_next !== 32'h500) begin n_fails++; $display("FAIL rf_last_wins got=%h exp=00000500", pc_next); end
        @(negedge clock);
        #2;
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h500}) begin n_fails++; $display("FAIL rf_target_fetch got req=%b addr=%h exp req=1 addr=00000500", imem_req, imem_addr); end
        n_checks++; if (fetch_count !== CW'(1)) begin n_fails++; $display("FAIL rf_count got=%0d exp=1", fetch_count); end
    endtask

    task automatic test_wrap();
        logic [31:0] p, e;
        p = 32'hFFFF_FFFC;
        mem_wait = 0; spurious = 1'b0;
        do_reset(p);
        instr_ready = 1'b1;
        for (int k = 0; k < 34; k++) begin
            #2;
            e = p + 32'(4 * (k / 2));
            if (k % 2 == 1) begin
                n_checks++; if ({instr_valid, instr_pc} !== {1'b1, e}) begin n_fails++; $display("FAIL wrap_issue k=%0d got val=%b pc=%h exp val=1 pc=%h", k, instr_valid, instr_pc, e); end
                if (k == 1) begin
                    n_checks++; if (pc_next !== 32'h0) begin n_fails++; $display("FAIL wrap_pcnext got=%h exp=00000000", pc_next); end
                end
            end else begin
                n_checks++; if ({imem_req, imem_addr} !== {1'b1, e}) begin n_fails++; $display("FAIL wrap_fetch k=%0d got req=%b addr=%h exp req=1 addr=%h", k, imem_req, imem_addr, e); end
            end
            n_checks++; if (fetch_count !== CW'((k / 2) % 16)) begin n_fails++; $display("FAIL wrap_count k=%0d got=%0d exp=%0d", k, fetch_count, (k / 2) % 16); end
            @(negedge clock);
        end
    endtask

    task automatic test_misalign();
        mem_wait = 0; spurious = 1'b0;
        do_reset(32'h0);
        instr_ready = 1'b1;
        @(negedge clock);
        redirect_valid = 1'b1; redirect_target = 32'h202;
        #2;
        n_checks++; if (pc_next !== 32'h202) begin n_fails++; $display("FAIL ma_pcnext got=%h exp=00000202", pc_next); end
        @(negedge clock);
        redirect_valid = 1'b0;
        #2;
`ifdef FETCH_MISALIGN_TRAP_EN
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("FAIL ma_noreq got=%b exp=0", imem_req); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            #2;
            n_checks++;
            if ({trap, instr_valid, imem_req, instr_pc, pc_next} !== {1'b1, 1'b0, 1'b0, 32'h202, 32'h202}) begin
                n_fails++; $display("FAIL ma_trap i=%0d got trap=%b val=%b req=%b pc=%h nxt=%h exp trap=1 val=0 req=0 pc=00000202 nxt=00000202", i, trap, instr_valid, imem_req, instr_pc, pc_next);
            end
        end
`else
        n_checks++; if ({imem_req, imem_addr, trap} !== {1'b1, 32'h200, 1'b0}) begin n_fails++; $display("FAIL ma_align got req=%b addr=%h trap=%b exp req=1 addr=00000200 trap=0", imem_req, imem_addr, trap); end
        @(negedge clock);
        #2;
        n_checks++;
        if ({instr_valid, instr_pc, instr_out, pc_next} !== {1'b1, 32'h202, memfun(32'h200), 32'h206}) begin
            n_fails++; $display("FAIL ma_issue got val=%b pc=%h ins=%h nxt=%h exp val=1 pc=00000202 ins=%h nxt=00000206", instr_valid, instr_pc, instr_out, pc_next, memfun(32'h200));
        end
`endif
    endtask

    task automatic test_reset_mid();
        mem_wait = 0; spurious = 1'b0;
        do_reset(32'h0);
        instr_ready = 1'b1;
        @(negedge clock);
        mem_wait = 10;
        @(negedge clock);
        @(negedge clock);
        #2;
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 32'h4}) begin n_fails++; $display("FAIL rm_pending got req=%b addr=%h exp req=1 addr=00000004", imem_req, imem_addr); end
        #1;
        reset = 1'b0;
        #1;
        n_checks++; if (imem_req !== 1'b0) begin n_fails++; $display("FAIL rm_async_drop got=%b exp=0", imem_req); end
        repeat (2) @(negedge clock);
        reset = 1'b1;
        mem_wait = 0;
        #2;
        n_checks++; if ({imem_req, imem_addr, fetch_count} !== {1'b1, 32'h0, CW'(0)}) begin n_fails++; $display("FAIL rm_restart got req=%b addr=%h cnt=%0d exp req=1 addr=00000000 cnt=0", imem_req, imem_addr, fetch_count); end
        @(negedge clock);
        #2;
        n_checks++; if ({instr_valid, instr_pc} !== {1'b1, 32'h0}) begin n_fails++; $display("FAIL rm_issue got val=%b pc=%h exp val=1 pc=00000000", instr_valid, instr_pc); end
    endtask

    // Stream model: accepted pcs run sequentially; a redirect seen while an instruction is
    // presented lets it retire and steers the one after, otherwise the in-flight fetch is lost.
    task automatic test_random();
        logic [31:0] exp_pc, pend_t;
        bit pend;
        int acc;
        pend = 1'b0; pend_t = '0; acc = 0;
        exp_pc = $urandom & 32'hFFFF_FFFC;
        mem_wait = -1; spurious = 1'b1;
        do_reset(exp_pc);
        for (int c = 0; c < 3000; c++) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 19) == 0);
            redirect_target = $urandom & 32'hFFFF_FFFC;
            #2;
            if (instr_valid && instr_ready) begin
                n_checks++;
                if ({instr_pc, instr_out} !== {exp_pc, memfun(exp_pc)}) begin
                    n_fails++; $display("FAIL rnd_stream c=%0d got pc=%h ins=%h exp pc=%h ins=%h", c, instr_pc, instr_out, exp_pc, memfun(exp_pc));
                end
                acc++;
                exp_pc = exp_pc + 32'd4;
                if (redirect_valid) exp_pc = redirect_target;
                else if (pend) exp_pc = pend_t;
                pend = 1'b0;
            end else if (redirect_valid) begin
                if (instr_valid) begin pend = 1'b1; pend_t = redirect_target; end
                else exp_pc = redirect_target;
            end
            @(negedge clock);
        end
        redirect_valid = 1'b0;
        instr_ready = 1'b0;
        #2;
        n_checks++; if (fetch_count !== CW'(acc % 16)) begin n_fails++; $display("FAIL rnd_count got=%0d exp=%0d", fetch_count, acc % 16); end
        n_checks++; if (acc < 100) begin n_fails++; $display("FAIL rnd_progress got=%0d exp>=100", acc); end
        spurious = 1'b0;
    endtask

    initial begin
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'h0;
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_ready_stall();
        test_redirect_wait();
        test_redirect_fetch();
        test_wrap();
        test_misalign();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fails++;
        $display("FAIL watchdog got=timeout exp=finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $fatal(1);
    end

endmodule
